axis_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing one AXI-stream sink between NUM_IN AXI-stream sources. Sources use the same tvalid/tready/tlast/data convention as the bench stream interface.
- Sits in front of the UART TX datapath, so several producers (e.g. CPU model and loopback) can feed one serializer without interleaving frames.
- Grant is held from the first beat of a packet until the tlast beat handshakes.

---
 rtl/axis_rr_arbiter.sv | 105 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_IN AXI-stream sources onto one sink.
// Grant holds from first beat until the tlast handshake; beats pass through unregistered.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_IN     = 4,
  localparam int IDX_W     = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            s_tvalid,
  input  logic [NUM_IN-1:0]            s_tlast,
  input  logic [NUM_IN*DATA_WIDTH-1:0] s_data,
  output logic [NUM_IN-1:0]            s_tready,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic [DATA_WIDTH-1:0]        m_data,
  input  logic                         m_tready,
  output logic                         grant_valid,
  output logic [IDX_W-1:0]             grant_idx
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [IDX_W:0]   NUM_W = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_IN - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  logic             busy;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  assign busy        = (state_q == BUSY);
  assign grant_valid = busy;
  assign grant_idx   = grant_idx_q;

  // Search rr_ptr, rr_ptr+1, ... with wrap; first valid source wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      cand = sum[IDX_W-1:0];
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    m_tvalid = busy & s_tvalid[grant_idx_q];
    m_tlast  = busy & s_tlast[grant_idx_q];
    m_data   = '0;
    s_tready = '0;
    if (busy) begin
      m_data                = s_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
      s_tready[grant_idx_q] = m_tready;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BUSY;
          grant_idx_d = win;
        end
      end
      BUSY: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == LAST) ? '0 : grant_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queue-driven sources, spec-level reference model,
// per-cycle compare, per-source frame scoreboard and directed literal checks.
module tb_axis_rr_arbiter;

  localparam int DW = 10;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  tv = '0;
  logic [N-1:0]  tl = '0;
  logic [N*DW-1:0] sd = '0;
  logic [N-1:0]  s_tready;
  logic          m_tvalid, m_tlast;
  logic [DW-1:0] m_data;
  logic          m_tready = 1'b0;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(tv), .s_tlast(tl), .s_data(sd), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_data(m_data),
    .m_tready(m_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  int checks = 0;
  int errors = 0;

  logic [DW:0] q_src[N][$];
  logic [DW:0] exp_q[N][$];
  int          glog[$];

  int gap_pct = 0;
  int rdy_pct = 100;
  bit rdy_force_en = 0;
  bit rdy_force_val = 0;
  bit drv_hold = 1;
  logic [N-1:0] hs_s = '0;

  // reference model state: busy flag, granted source, round-robin pointer
  bit mb = 0;
  int mg = 0;
  int mp = 0;
  int wait_cnt[N];

  logic [N-1:0]    prev_tv;
  logic [N*DW-1:0] prev_sd;
  logic [N-1:0]    prev_hs;
  bit              prev_ok = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(int s, logic [DW-1:0] d, bit last);
    q_src[s].push_back({last, d});
    exp_q[s].push_back({last, d});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(string name, int maxc);
    int c;
    bit pend;
    c = 0;
    pend = 1;
    while (pend && c < maxc) begin
      tick();
      c++;
      pend = mb || (tv != '0);
      for (int i = 0; i < N; i++) if (q_src[i].size() != 0) pend = 1;
    end
    checks++;
    if (pend) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, c);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    drv_hold = 1;
    rst = 1;
    for (int i = 0; i < N; i++) begin
      q_src[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(negedge clk);
    #2;
    rst = 0;
    drv_hold = 0;
    glog.delete();
  endtask

  // Sources: present queue head, hold until handshake, optional random gaps.
  always @(posedge clk) begin
    #1;
    if (drv_hold) begin
      tv = '0;
      tl = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hs_s[i]) begin
          void'(q_src[i].pop_front());
          tv[i] = 1'b0;
        end
        if (!tv[i] && q_src[i].size() != 0 &&
            int'($urandom_range(99)) >= gap_pct) begin
          tv[i] = 1'b1;
          tl[i] = q_src[i][0][DW];
          sd[i*DW +: DW] = q_src[i][0][DW-1:0];
        end
      end
    end
    if (rdy_force_en) m_tready = rdy_force_val;
    else m_tready = (int'($urandom_range(99)) < rdy_pct);
  end

  // Compare process: expected outputs from the model, then advance the model.
  always @(negedge clk) begin
    logic          e_mtv, e_last;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_str;
    int            w;
    bit            fnd;
    if (rst) begin
      mb = 0; mg = 0; mp = 0;
      hs_s = '0;
      prev_ok = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      chk("reset_outputs",
          64'({m_tvalid, m_tlast, m_data, s_tready, grant_valid, grant_idx}),
          64'(0));
    end else begin
      e_mtv  = mb ? tv[mg] : 1'b0;
      e_last = mb ? tl[mg] : 1'b0;
      e_data = mb ? sd[mg*DW +: DW] : '0;
      e_str  = '0;
      if (mb) e_str[mg] = m_tready;
      chk("cycle",
          64'({m_tvalid, m_tlast, m_data, s_tready, grant_valid, grant_idx}),
          64'({e_mtv, e_last, e_data, e_str, mb, IW'(mg)}));
      hs_s = tv & s_tready;
      if (prev_ok && !drv_hold) begin
        for (int i = 0; i < N; i++) begin
          if (prev_tv[i] && !prev_hs[i])
            chk("axis_hold", 64'({tv[i], sd[i*DW +: DW]}),
                64'({1'b1, prev_sd[i*DW +: DW]}));
        end
      end
      prev_tv = tv;
      prev_sd = sd;
      prev_hs = hs_s;
      prev_ok = !drv_hold;
      if (!mb) begin
        if (tv != '0) begin
          fnd = 0;
          w = 0;
          for (int k = 0; k < N; k++) begin
            if (!fnd && tv[(mp + k) % N]) begin
              fnd = 1;
              w = (mp + k) % N;
            end
          end
          mb = 1;
          mg = w;
          glog.push_back(w);
          for (int i = 0; i < N; i++) begin
            if (i == w || !tv[i]) wait_cnt[i] = 0;
            else begin
              wait_cnt[i]++;
              chk("starve", 64'(wait_cnt[i] < N), 64'(1));
            end
          end
        end
      end else if (e_mtv && m_tready) begin
        if (exp_q[mg].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: unexpected beat %0h from src %0d", m_data, mg);
        end else begin
          chk("frame", 64'({m_tlast, m_data}), 64'(exp_q[mg].pop_front()));
        end
        if (m_tlast) begin
          mb = 0;
          mp = (mg + 1) % N;
        end
      end
    end
  end

  initial begin
    int e2[5];
    int cnt[N];
    int seq[N];
    int s, len;
    e2 = '{0, 1, 2, 3, 0};

    #1;
    chk("rst_async", 64'({m_tvalid, s_tready, grant_valid, m_data}), 64'(0));
    repeat (2) @(negedge clk);
    #2;
    rst = 0;
    drv_hold = 0;

    // single 3-beat packet from source 1
    tick();
    glog.delete();
    load(1, 10'h011, 0);
    load(1, 10'h022, 0);
    load(1, 10'h033, 1);
    tick();
    chk("t1_lat_idle", 64'(m_tvalid), 64'(0));
    tick();
    chk("t1_b1", 64'({m_tvalid, m_data, grant_valid, grant_idx}),
        64'({1'b1, 10'h011, 1'b1, 2'd1}));
    tick();
    chk("t1_b2", 64'({m_tvalid, m_tlast, m_data}), 64'({2'b10, 10'h022}));
    tick();
    chk("t1_b3", 64'({m_tvalid, m_tlast, m_data}), 64'({2'b11, 10'h033}));
    tick();
    chk("t1_idle", 64'({m_tvalid, grant_valid, grant_idx}), 64'({2'b00, 2'd1}));
    load(0, 10'h0A0, 1);
    load(2, 10'h0A2, 1);
    wait_idle("t1_wait", 100);
    chk("t1_n", 64'(glog.size()), 64'(3));
    chk("t1_ptr2_a", 64'(glog[1]), 64'(2));
    chk("t1_ptr2_b", 64'(glog[2]), 64'(0));

    // all sources continuously valid, 2-beat packets
    do_reset();
    load(0, 10'h100, 0); load(0, 10'h101, 1);
    load(0, 10'h102, 0); load(0, 10'h103, 1);
    for (int i = 1; i < N; i++) begin
      load(i, 10'(i * 16), 0);
      load(i, 10'(i * 16 + 1), 1);
    end
    wait_idle("t2_wait", 200);
    chk("t2_n", 64'(glog.size()), 64'(5));
    for (int k = 0; k < 5; k++) chk("t2_order", 64'(glog[k]), 64'(e2[k]));

    // no preemption of source 0 by source 2, random backpressure
    do_reset();
    rdy_pct = 50;
    for (int k = 0; k < 4; k++) load(0, 10'(10'h0C0 + k), k == 3);
    begin
      int c;
      c = 0;
      while (q_src[0].size() == 4 && c < 200) begin
        tick();
        c++;
      end
      chk("t3_first_beat", 64'(c < 200), 64'(1));
    end
    load(2, 10'h2C0, 0);
    load(2, 10'h2C1, 1);
    wait_idle("t3_wait", 500);
    chk("t3_n", 64'(glog.size()), 64'(2));
    chk("t3_g0", 64'(glog[0]), 64'(0));
    chk("t3_g1", 64'(glog[1]), 64'(2));
    rdy_pct = 100;

    // 1-beat packet from source 3 under 5 cycles of backpressure
    do_reset();
    load(2, 10'h2AA, 1);
    wait_idle("t4_pre", 100);
    rdy_force_en = 1;
    rdy_force_val = 0;
    load(3, 10'h3C3, 1);
    tick();
    chk("t4_idle", 64'(m_tvalid), 64'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_hold", 64'({m_tvalid, m_tlast, m_data}), 64'({2'b11, 10'h3C3}));
      if (k == 4) rdy_force_val = 1;
    end
    tick();
    chk("t4_done", 64'({m_tvalid, grant_valid}), 64'(0));
    rdy_force_en = 0;
    load(0, 10'h0F0, 1);
    load(3, 10'h3F3, 1);
    wait_idle("t4_wait", 100);
    chk("t4_n", 64'(glog.size()), 64'(4));
    chk("t4_g", 64'({8'(glog[0]), 8'(glog[1]), 8'(glog[2]), 8'(glog[3])}),
        64'({8'd2, 8'd3, 8'd0, 8'd3}));

    // reset during beat 2 of a 4-beat packet from source 1
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 10'(10'h1B1 + k), k == 3);
    tick();
    tick();
    tick();
    chk("t5_b2", 64'({m_tvalid, m_data}), 64'({1'b1, 10'h1B2}));
    #1;
    drv_hold = 1;
    rst = 1;
    for (int i = 0; i < N; i++) begin
      q_src[i].delete();
      exp_q[i].delete();
    end
    #1;
    chk("t5_async", 64'({m_tvalid, s_tready, grant_valid, grant_idx}), 64'(0));
    repeat (2) @(negedge clk);
    #2;
    rst = 0;
    drv_hold = 0;
    glog.delete();
    load(1, 10'h1D1, 1);
    load(2, 10'h2D2, 1);
    wait_idle("t5_wait", 100);
    chk("t5_n", 64'(glog.size()), 64'(2));
    chk("t5_g0", 64'(glog[0]), 64'(1));
    chk("t5_g1", 64'(glog[1]), 64'(2));

    // randomized frames on all sources
    do_reset();
    gap_pct = 30;
    rdy_pct = 70;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      seq[i] = 0;
    end
    for (int p = 0; p < 1000; p++) begin
      s = int'($urandom_range(N - 1));
      len = int'($urandom_range(4, 1));
      cnt[s]++;
      for (int b = 0; b < len; b++) begin
        load(s, {2'(s), 8'(seq[s])}, b == len - 1);
        seq[s]++;
      end
    end
    wait_idle("t6_wait", 60000);
    chk("t6_packets", 64'(glog.size()), 64'(1000));
    for (int i = 0; i < N; i++) begin
      chk("t6_drained", 64'(exp_q[i].size()), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
